// File: rtl/lm75_ctrl_pkg.sv
// Shared definitions for the LM75 polling sequencer: core register map,
// command codes, status bit positions, FSM states and the step decode.
package lm75_ctrl_pkg;

    localparam logic [2:0] CMD_START   = 3'd0;
    localparam logic [2:0] CMD_WR      = 3'd1;
    localparam logic [2:0] CMD_RD      = 3'd2;
    localparam logic [2:0] CMD_STOP    = 3'd3;
    localparam logic [2:0] CMD_RESTART = 3'd4;

    localparam logic [4:0] ADDR_STATUS = 5'd0;
    localparam logic [4:0] ADDR_DVSR   = 5'd1;
    localparam logic [4:0] ADDR_CMD    = 5'd2;

    localparam int unsigned BIT_READY = 8;
    localparam int unsigned BIT_ACK   = 9;

    localparam logic [2:0] STEP_WR_ADDR_W = 3'd1;
    localparam logic [2:0] STEP_WR_PTR    = 3'd2;
    localparam logic [2:0] STEP_WR_ADDR_R = 3'd4;
    localparam logic [2:0] STEP_RD_MSB    = 3'd5;
    localparam logic [2:0] STEP_RD_LSB    = 3'd6;
    localparam logic [2:0] STEP_STOP      = 3'd7;

    typedef enum logic [2:0] {
        ST_INIT,
        ST_IDLE,
        ST_ISSUE,
        ST_GAP,
        ST_WAIT,
        ST_DONE,
        ST_ABORT
    } ctrl_state_t;

    // {cmd, din} for each step of a complete pointer-then-read transaction
    function automatic logic [10:0] step_word(input logic [2:0] step,
                                              input logic [6:0] dev_addr,
                                              input logic [7:0] ptr);
        logic [10:0] w;
        w = {CMD_STOP, 8'h00};
        case (step)
            3'd0:    w = {CMD_START, 8'h00};
            3'd1:    w = {CMD_WR, dev_addr, 1'b0};
            3'd2:    w = {CMD_WR, ptr};
            3'd3:    w = {CMD_RESTART, 8'h00};
            3'd4:    w = {CMD_WR, dev_addr, 1'b1};
            3'd5:    w = {CMD_RD, 8'h00};
            3'd6:    w = {CMD_RD, 8'h01};
            default: w = {CMD_STOP, 8'h00};
        endcase
        return w;
    endfunction

endpackage

// File: rtl/lm75_poll_ctrl_if.sv
// Register bus between the polling sequencer (master) and the I2C core (slave).
interface lm75_poll_ctrl_if;
    logic        cs;
    logic        read;
    logic        write;
    logic [4:0]  addr;
    logic [31:0] wr_data;
    logic [31:0] rd_data;

    modport master (output cs, read, write, addr, wr_data, input rd_data);
    modport slave  (input cs, read, write, addr, wr_data, output rd_data);
endinterface

// File: rtl/lm75_poll_ctrl.sv
// Sequences complete LM75 temperature reads over the I2C core register bus,
// triggered periodically or on demand, with NACK abort and ready timeout.
module lm75_poll_ctrl
    import lm75_ctrl_pkg::*;
#(
    parameter logic [6:0]  DEV_ADDR    = 7'h48,
    parameter logic [7:0]  PTR         = 8'h00,
    parameter logic [15:0] DVSR        = 16'd250,
    parameter int unsigned POLL_CYCLES = 1_000_000,
    parameter int unsigned TIMEOUT     = 65_535
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    enable,
    input  logic                    start,
    lm75_poll_ctrl_if.master        bus,
    output logic [15:0]             temp_raw,
    output logic                    temp_valid,
    output logic                    busy,
    output logic                    err
);

    localparam int unsigned CW = 32;
    localparam logic [CW-1:0] POLL_LOAD = CW'(POLL_CYCLES - 1);
    localparam logic [CW-1:0] TMO_LAST  = CW'(TIMEOUT - 1);

    ctrl_state_t   r_state;
    logic [2:0]    r_step;
    logic          r_abort;
    logic [CW-1:0] r_poll;
    logic [CW-1:0] r_tmo;
    logic [7:0]    r_msb;
    logic [7:0]    r_lsb;
    logic          r_cs;
    logic          r_read;
    logic          r_write;
    logic [4:0]    r_addr;
    logic [31:0]   r_wr_data;
    logic [15:0]   r_temp_raw;
    logic          r_temp_valid;
    logic          r_busy;
    logic          r_err;

    logic          w_ready;
    logic          w_nack;
    logic          w_trigger;
    logic          w_ack_step;
    logic [2:0]    w_next_step;
    logic          w_unused_rd;

    assign w_ready     = bus.rd_data[BIT_READY];
    assign w_nack      = bus.rd_data[BIT_ACK];
    assign w_trigger   = start || (enable && (r_poll == '0));
    assign w_ack_step  = (r_step == STEP_WR_ADDR_W) || (r_step == STEP_WR_PTR) ||
                         (r_step == STEP_WR_ADDR_R);
    assign w_next_step = r_step + 3'd1;
    assign w_unused_rd = ^bus.rd_data[31:10];

    // Strobes default low each cycle; states that drive the bus re-assert them.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= ST_INIT;
            r_step       <= '0;
            r_abort      <= 1'b0;
            r_poll       <= '0;
            r_tmo        <= '0;
            r_msb        <= '0;
            r_lsb        <= '0;
            r_cs         <= 1'b0;
            r_read       <= 1'b0;
            r_write      <= 1'b0;
            r_addr       <= '0;
            r_wr_data    <= '0;
            r_temp_raw   <= '0;
            r_temp_valid <= 1'b0;
            r_busy       <= 1'b0;
            r_err        <= 1'b0;
        end else begin
            r_cs         <= 1'b0;
            r_read       <= 1'b0;
            r_write      <= 1'b0;
            r_temp_valid <= 1'b0;
            r_err        <= 1'b0;
            case (r_state)
                ST_INIT: begin
                    r_cs      <= 1'b1;
                    r_write   <= 1'b1;
                    r_addr    <= ADDR_DVSR;
                    r_wr_data <= 32'(DVSR);
                    r_poll    <= POLL_LOAD;
                    r_state   <= ST_IDLE;
                end
                ST_IDLE: begin
                    if (w_trigger) begin
                        r_step    <= 3'd0;
                        r_abort   <= 1'b0;
                        r_busy    <= 1'b1;
                        r_cs      <= 1'b1;
                        r_write   <= 1'b1;
                        r_addr    <= ADDR_CMD;
                        r_wr_data <= 32'(step_word(3'd0, DEV_ADDR, PTR));
                        r_state   <= ST_ISSUE;
                    end else if (enable) begin
                        r_poll <= r_poll - CW'(1);
                    end
                end
                ST_ISSUE: begin
                    r_state <= ST_GAP;
                end
                ST_GAP: begin
                    r_cs    <= 1'b1;
                    r_read  <= 1'b1;
                    r_addr  <= ADDR_STATUS;
                    r_tmo   <= '0;
                    r_state <= ST_WAIT;
                end
                ST_WAIT: begin
                    if (w_ready) begin
                        if (!r_abort && w_ack_step && w_nack) begin
                            // Release the bus cleanly before reporting the NACK
                            r_abort   <= 1'b1;
                            r_step    <= STEP_STOP;
                            r_cs      <= 1'b1;
                            r_write   <= 1'b1;
                            r_addr    <= ADDR_CMD;
                            r_wr_data <= 32'(step_word(STEP_STOP, DEV_ADDR, PTR));
                            r_state   <= ST_ISSUE;
                        end else if (r_step == STEP_STOP) begin
                            if (r_abort) begin
                                r_err   <= 1'b1;
                                r_state <= ST_ABORT;
                            end else begin
                                r_temp_raw   <= {r_msb, r_lsb};
                                r_temp_valid <= 1'b1;
                                r_state      <= ST_DONE;
                            end
                        end else begin
                            if (r_step == STEP_RD_MSB) r_msb <= bus.rd_data[7:0];
                            if (r_step == STEP_RD_LSB) r_lsb <= bus.rd_data[7:0];
                            r_step    <= w_next_step;
                            r_cs      <= 1'b1;
                            r_write   <= 1'b1;
                            r_addr    <= ADDR_CMD;
                            r_wr_data <= 32'(step_word(w_next_step, DEV_ADDR, PTR));
                            r_state   <= ST_ISSUE;
                        end
                    end else if (r_tmo == TMO_LAST) begin
                        r_err   <= 1'b1;
                        r_busy  <= 1'b0;
                        r_poll  <= POLL_LOAD;
                        r_state <= ST_IDLE;
                    end else begin
                        r_tmo  <= r_tmo + CW'(1);
                        r_cs   <= 1'b1;
                        r_read <= 1'b1;
                    end
                end
                ST_DONE, ST_ABORT: begin
                    r_busy  <= 1'b0;
                    r_poll  <= POLL_LOAD;
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_INIT;
                end
            endcase
        end
    end

    assign bus.cs      = r_cs;
    assign bus.read    = r_read;
    assign bus.write   = r_write;
    assign bus.addr    = r_addr;
    assign bus.wr_data = r_wr_data;
    assign temp_raw    = r_temp_raw;
    assign temp_valid  = r_temp_valid;
    assign busy        = r_busy;
    assign err         = r_err;

endmodule

// File: tb/tb_lm75_poll_ctrl.sv
// Randomized bench for lm75_poll_ctrl: an I2C-core slave model answers the
// command stream and a transaction-level model predicts commands and results.
module tb_lm75_poll_ctrl;

    localparam int DEV   = 'h48;
    localparam int PTRV  = 'h00;
    localparam int DVSRV = 250;
    localparam int POLL  = 100;
    localparam int TMO   = 50;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        enable;
    logic        start;
    logic [15:0] temp_raw;
    logic        temp_valid;
    logic        busy;
    logic        err;

    lm75_poll_ctrl_if bus();

    lm75_poll_ctrl #(
        .DEV_ADDR   (7'h48),
        .PTR        (8'h00),
        .DVSR       (16'd250),
        .POLL_CYCLES(POLL),
        .TIMEOUT    (TMO)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .enable    (enable),
        .start     (start),
        .bus       (bus),
        .temp_raw  (temp_raw),
        .temp_valid(temp_valid),
        .busy      (busy),
        .err       (err)
    );

    always #5 clk = ~clk;

    // slave model state
    int          delay;
    bit          stall;
    logic        ready;
    logic        ack;
    logic [7:0]  dout;
    int          nack_sel;
    logic [7:0]  plan_msb, plan_lsb;
    int          wr_idx, rd_idx;

    assign bus.rd_data = {22'd0, ack, ready, dout};

    // observation
    logic [31:0] cmd_q[$];
    logic [31:0] exp_q[$];
    int          valid_cnt, err_cnt, strobe_viol, wait_cycles;
    int          cyc, start_cyc, idle_cyc, dvsr_cnt;
    logic [31:0] dvsr_data;
    logic        err_busy;
    logic        prev_busy;
    bit          saw_rd_ack;
    logic [15:0] exp_temp;

    int checks;
    int errors;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Slave + monitor, evaluated just after each active edge
    always @(posedge clk) begin
        #1;
        cyc++;
        if (rst_n) begin
            if ((bus.cs != (bus.read | bus.write)) || (bus.read && bus.write))
                strobe_viol++;
            if (bus.cs && bus.write && bus.addr == 5'd1) begin
                dvsr_cnt++;
                dvsr_data = bus.wr_data;
            end
            if (bus.cs && bus.write && bus.addr == 5'd2) begin
                cmd_q.push_back(bus.wr_data);
                if (bus.wr_data == 32'h000) begin
                    start_cyc = cyc;
                    wr_idx = 0;
                    rd_idx = 0;
                end
                if (bus.wr_data == 32'h200) saw_rd_ack = 1'b1;
                delay = $urandom_range(0, 3);
                ack = 1'b0;
                if (bus.wr_data[10:8] == 3'd1) begin
                    wr_idx++;
                    ack = (wr_idx == nack_sel);
                end
                if (bus.wr_data[10:8] == 3'd2) begin
                    dout = (rd_idx == 0) ? plan_msb : plan_lsb;
                    rd_idx++;
                end
            end else if (bus.cs && bus.read && bus.addr == 5'd0) begin
                wait_cycles++;
                if (delay > 0) delay--;
            end
            ready = !stall && (delay == 0);
            if (temp_valid) valid_cnt++;
            if (err) begin
                err_cnt++;
                err_busy = busy;
            end
            if (prev_busy && !busy) idle_cyc = cyc;
            prev_busy = busy;
        end
    end

    // Expected command list for one transaction; nsel picks which WR byte is NACKed
    function automatic void build_exp(input int nsel);
        logic [31:0] w[8];
        int last;
        w[0] = 32'(0);
        w[1] = 32'(256 + DEV * 2);
        w[2] = 32'(256 + PTRV);
        w[3] = 32'(4 * 256);
        w[4] = 32'(256 + DEV * 2 + 1);
        w[5] = 32'(2 * 256);
        w[6] = 32'(2 * 256 + 1);
        w[7] = 32'(3 * 256);
        exp_q.delete();
        last = (nsel == 1) ? 1 : (nsel == 2) ? 2 : (nsel == 3) ? 4 : 7;
        for (int i = 0; i <= last; i++) exp_q.push_back(w[i]);
        if (nsel != 0) exp_q.push_back(w[7]);
    endfunction

    // mode 0: start pulse, 1: poll timer, 2: poll timer with start in the expiry cycle
    task automatic run_txn(input logic [7:0] m, input logic [7:0] l, input int nsel,
                           input int mode, input bit noisy, input string tag);
        int n;
        int prev_idle;
        plan_msb = m;
        plan_lsb = l;
        nack_sel = nsel;
        cmd_q.delete();
        valid_cnt = 0;
        err_cnt = 0;
        build_exp(nsel);
        prev_idle = idle_cyc;
        if (mode == 0) begin
            @(negedge clk) start = 1'b1;
            @(negedge clk) start = 1'b0;
        end else if (mode == 2) begin
            n = 0;
            while (cyc < prev_idle + POLL - 1 && n < 300) begin
                @(negedge clk);
                n++;
            end
            start = 1'b1;
            @(negedge clk) start = 1'b0;
        end
        n = 0;
        while (!busy && n < 300) begin
            @(negedge clk);
            n++;
        end
        check({tag, " busy_rise"}, 32'(busy), 32'd1);
        if (mode != 0) check({tag, " poll_interval"}, 32'(start_cyc - prev_idle), 32'(POLL));
        n = 0;
        while (busy && n < 3000) begin
            start = noisy && ($urandom_range(0, 3) == 0);
            @(negedge clk);
            n++;
        end
        start = 1'b0;
        check({tag, " busy_fall"}, 32'(busy), 32'd0);
        repeat (2) @(negedge clk);
        check({tag, " cmd_count"}, 32'(cmd_q.size()), 32'(exp_q.size()));
        for (int i = 0; i < exp_q.size(); i++)
            if (i < cmd_q.size())
                check($sformatf("%s cmd%0d", tag, i), cmd_q[i], exp_q[i]);
        if (nsel == 0) exp_temp = {m, l};
        check({tag, " valid_pulses"}, 32'(valid_cnt), (nsel == 0) ? 32'd1 : 32'd0);
        check({tag, " err_pulses"}, 32'(err_cnt), (nsel == 0) ? 32'd0 : 32'd1);
        check({tag, " temp_raw"}, 32'(temp_raw), 32'(exp_temp));
    endtask

    initial begin
        int n;
        checks = 0;
        errors = 0;
        rst_n = 1'b0;
        enable = 1'b0;
        start = 1'b0;
        stall = 1'b0;
        delay = 0;
        ready = 1'b0;
        ack = 1'b0;
        dout = 8'h00;
        nack_sel = 0;
        exp_temp = 16'h0000;
        prev_busy = 1'b0;
        dvsr_cnt = 0;

        // reset state
        repeat (3) @(negedge clk);
        check("reset strobes", {29'd0, bus.cs, bus.read, bus.write}, 32'd0);
        check("reset addr", 32'(bus.addr), 32'd0);
        check("reset wr_data", bus.wr_data, 32'd0);
        check("reset outs", {13'd0, temp_raw, temp_valid, busy, err}, 32'd0);

        // first bus cycle after release is the divisor write
        rst_n = 1'b1;
        @(negedge clk);
        check("init write", {29'd0, bus.cs, bus.read, bus.write}, 32'd5);
        check("init addr", 32'(bus.addr), 32'd1);
        check("init dvsr", bus.wr_data, 32'(DVSRV));
        repeat (3) @(negedge clk);

        run_txn(8'h19, 8'h80, 0, 0, 1, "good");
        run_txn(8'h55, 8'haa, 1, 0, 1, "nack_addr");
        for (int i = 0; i < 6; i++)
            run_txn(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)),
                    int'($urandom_range(0, 3)), 0, 1, $sformatf("rand%0d", i));

        // periodic polling
        enable = 1'b1;
        run_txn(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)), 0, 0, 1, "poll_seed");
        run_txn(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)), 0, 1, 1, "poll1");
        run_txn(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)), 2, 1, 1, "poll2");
        run_txn(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)), 0, 2, 0, "poll_coinc");
        enable = 1'b0;
        repeat (3) @(negedge clk);

        // ready never returns
        stall = 1'b1;
        cmd_q.delete();
        valid_cnt = 0;
        err_cnt = 0;
        wait_cycles = 0;
        err_busy = 1'b1;
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
        n = 0;
        while (busy && n < 500) begin
            @(negedge clk);
            n++;
        end
        repeat (2) @(negedge clk);
        check("tmo cmd_count", 32'(cmd_q.size()), 32'd1);
        if (cmd_q.size() > 0) check("tmo cmd0", cmd_q[0], 32'h000);
        check("tmo wait_cycles", 32'(wait_cycles), 32'(TMO));
        check("tmo err_pulses", 32'(err_cnt), 32'd1);
        check("tmo busy_at_err", 32'(err_busy), 32'd0);
        check("tmo valid", 32'(valid_cnt), 32'd0);
        check("tmo temp_raw", 32'(temp_raw), 32'(exp_temp));
        stall = 1'b0;
        repeat (3) @(negedge clk);

        // reset in the middle of the MSB read
        plan_msb = 8'h12;
        plan_lsb = 8'h34;
        nack_sel = 0;
        saw_rd_ack = 1'b0;
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
        n = 0;
        while (!saw_rd_ack && n < 500) begin
            @(negedge clk);
            n++;
        end
        check("mid saw_step5", 32'(saw_rd_ack), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        check("mid rst strobes", {29'd0, bus.cs, bus.read, bus.write}, 32'd0);
        check("mid rst addr", 32'(bus.addr), 32'd0);
        check("mid rst wr_data", bus.wr_data, 32'd0);
        check("mid rst outs", {13'd0, temp_raw, temp_valid, busy, err}, 32'd0);
        exp_temp = 16'h0000;
        repeat (3) @(negedge clk);
        dvsr_cnt = 0;
        rst_n = 1'b1;
        @(negedge clk);
        check("mid re-init write", {29'd0, bus.cs, bus.read, bus.write}, 32'd5);
        check("mid re-init addr", 32'(bus.addr), 32'd1);
        check("mid re-init dvsr", bus.wr_data, 32'(DVSRV));
        repeat (3) @(negedge clk);
        check("mid dvsr_count", 32'(dvsr_cnt), 32'd1);
        run_txn(8'h1f, 8'h00, 0, 0, 0, "recover");

        check("strobe_excl", 32'(strobe_viol), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
